// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff_o = num1_i - num2_i (mod 2^WIDTH),
// one CHUNK-bit digit per clock, least-significant digit first, rippling the borrow.
module serial_subtractor #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] num1_i,
   input  logic [WIDTH-1:0] num2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic [1:0]       state_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             brw_q, borrow_q;
   logic             accept, last;
   logic [CHUNK:0]   sub;

   // Handshake: a start is accepted on any edge where start_i=1 and the block
   // is not in RUN (IDLE or DONE); operands are sampled only on that edge.
   // done_o pulses for one cycle; diff_o/borrow_o then hold until the next accept.
   assign last = (cnt_q == CW'(NCHUNK - 1));
   assign sub  = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
               - {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
               - {{CHUNK{1'b0}}, brw_q};

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               accept  = 1'b1;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            if (start_i) begin
               state_d = RUN;
               accept  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         brw_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q      <= num1_i;
            b_q      <= num2_i;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
         end else if (state_q == RUN) begin
            diff_q[cnt_q*CHUNK +: CHUNK] <= sub[CHUNK-1:0];
            brw_q <= sub[CHUNK];
            cnt_q <= cnt_q + CW'(1);
            // The borrow out of the top digit is the unsigned less-than flag.
            if (last) borrow_q <= sub[CHUNK];
         end
      end
   end

   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=64, CHUNK=8): latency, wrap-around,
// sweep, back-to-back, mid-run reset and operand stability.
module tb_serial_subtractor;

   localparam int WIDTH  = 64;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] num1, num2;
   logic             busy, done, borrow;
   logic [WIDTH-1:0] diff;
   logic [1:0]       state;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .num1_i   (num1),
      .num2_i   (num2),
      .busy_o   (busy),
      .done_o   (done),
      .diff_o   (diff),
      .borrow_o (borrow),
      .state_o  (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advances edge by edge (sampling #1 after each) until done_o, bounded.
   task automatic wait_done(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!done && edges < 40);
   endtask

   task automatic check_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_d, input logic exp_b, input string tag);
      int lat;
      @(negedge clk);
      num1  = a;
      num2  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      wait_done(lat);
      check({tag, "_lat"}, WIDTH'(lat), WIDTH'(NCHUNK));
      check({tag, "_diff"}, diff, exp_d);
      check({tag, "_borrow"}, {63'd0, borrow}, {63'd0, exp_b});
   endtask

   initial begin
      logic [WIDTH-1:0] i, j, hold_d;
      int lat, lat2;

      rst_n = 1'b0;
      start = 1'b0;
      num1  = '0;
      num2  = '0;
      #12;
      check("rst_busy",   {63'd0, busy},   64'd0);
      check("rst_done",   {63'd0, done},   64'd0);
      check("rst_diff",   diff,            64'd0);
      check("rst_borrow", {63'd0, borrow}, 64'd0);
      check("rst_state",  {62'd0, state},  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic and boundary vectors
      check_op(64'd5, 64'd3, 64'd2, 1'b0, "t1_5m3");
      // Result must hold after done_o with the block back in IDLE
      @(posedge clk);
      #1;
      check("t1_done_pulse", {63'd0, done}, 64'd0);
      check("t1_idle",       {62'd0, state}, 64'd0);
      check("t1_hold",       diff, 64'd2);
      check_op(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "t2_3m5");
      check_op(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "t2_0m1");
      check_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, "t2_maxmmax");
      check_op(64'h0100_0000_0000_0000, 64'h0000_0000_0000_0001,
               64'h00FF_FFFF_FFFF_FFFF, 1'b0, "t2_ripple");

      // Geometric sweep of operand pairs
      i = 64'd1;
      while (i < 64'd1000000) begin
         j = 64'd1;
         while (j < 64'd1000000) begin
            check_op(i, j, i - j, (i < j), "t3_sweep");
            j = j * 64'd73;
         end
         i = i * 64'd59;
      end

      // Back-to-back: start held high through RUN and DONE
      @(negedge clk);
      num1  = 64'd100;
      num2  = 64'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      num1 = 64'd7;
      num2 = 64'd9;
      wait_done(lat);
      check("t4_lat1",  WIDTH'(lat), WIDTH'(NCHUNK));
      check("t4_diff1", diff, 64'd99);
      check("t4_brw1",  {63'd0, borrow}, 64'd0);
      wait_done(lat2);
      start = 1'b0;
      check("t4_gap",   WIDTH'(lat2), WIDTH'(NCHUNK + 1));
      check("t4_diff2", diff, 64'hFFFF_FFFF_FFFF_FFFE);
      check("t4_brw2",  {63'd0, borrow}, 64'd1);
      @(posedge clk);
      #1;
      check("t4_idle", {62'd0, state}, 64'd0);

      // Reset mid-run aborts with outputs cleared and no done_o
      @(negedge clk);
      num1  = 64'h1234_5678_9ABC_DEF0;
      num2  = 64'h0FED_CBA9_8765_4321;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_busy",   {63'd0, busy},   64'd0);
      check("t5_diff",   diff,            64'd0);
      check("t5_borrow", {63'd0, borrow}, 64'd0);
      repeat (6) begin
         @(posedge clk);
         #1;
         check("t5_nodone", {63'd0, done}, 64'd0);
      end
      // Start asserted while reset is held: reset wins
      start = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_start", {63'd0, busy}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
               64'h0246_8ACF_1357_9BCF, 1'b0, "t5_after");

      // Operand churn and a stray start during RUN must not matter
      @(negedge clk);
      num1  = 64'hDEAD_BEEF_0000_0001;
      num2  = 64'hDEAD_BEEF_0000_0002;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      for (int k = 0; k < NCHUNK - 1; k++) begin
         @(negedge clk);
         num1  = {$urandom, $urandom};
         num2  = {$urandom, $urandom};
         start = (k == 3);
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (!done) begin
         wait_done(lat2);
         lat = lat + lat2;
      end
      check("t6_lat",    WIDTH'(lat), WIDTH'(NCHUNK));
      check("t6_diff",   diff, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t6_borrow", {63'd0, borrow}, 64'd1);
      hold_d = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check("t6_hold",  diff, hold_d);
      check("t6_idle",  {62'd0, state}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
